// File: rtl/iiitb_seq_pkg.sv
// Shared types and constants for the iiitb serial pattern transmitter
// and its optional "1010" occurrence counter.
package iiitb_seq_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Pattern recognised by the downstream detector
    localparam logic [3:0] PATTERN = 4'b1010;

    // Width of the occurrence counter
    localparam int CNT_W = 16;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/iiitb_seq_patcnt.sv
// Overlapping "1010" occurrence counter on a serial stream.
// Samples din every clock; the count rises in the cycle after the
// completing 0 and saturates at all-ones. Usable as a detector reference.
module iiitb_seq_patcnt
    import iiitb_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [CNT_W-1:0] cnt
);

    logic [2:0]       hist_r;
    logic [CNT_W-1:0] cnt_r;
    logic             match_s;

    // Compare the three previous bits plus the current bit to the pattern
    always_comb begin
        match_s = ({hist_r, din} == PATTERN);
    end

    // History shift register and saturating occurrence count
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_r <= 3'b000;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            hist_r <= {hist_r[1:0], din};
            if (match_s) begin
                cnt_r <= sat_inc(cnt_r);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/iiitb_seq_tx.sv
// Serial pattern transmitter: takes a word plus bit count over valid/ready
// and shifts it out MSB-first, one bit per clock, with optional idle gap.
// Optional build macro IIITB_SEQ_TX_CNT_EN adds exp_cnt, a saturating
// count of overlapping "1010" occurrences seen on dout.
module iiitb_seq_tx
    import iiitb_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int LENW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic [LENW-1:0]  len,
    input  logic             valid,
    output logic             ready,
    output logic             dout,
    output logic             dout_vld,
    output logic             last,
    output logic             busy
`ifdef IIITB_SEQ_TX_CNT_EN
    ,
    output logic [CNT_W-1:0] exp_cnt
`endif
);

    localparam logic [LENW-1:0] WIDTH_L = LENW'(WIDTH);
    localparam logic [3:0]      GAP_L   = 4'(GAP_CYCLES);
    localparam bit              HAS_GAP = (GAP_CYCLES > 0);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [LENW-1:0]  cnt_r, cnt_s;     // bits left, including the one on dout
    logic [3:0]       gap_r, gap_s;
    logic             dout_r, dout_s;
    logic             vld_r, vld_s;
    logic             last_r, last_s;

    logic [LENW-1:0]  len_eff_s;
    logic [WIDTH-1:0] aligned_s;
    logic             ready_s;
    logic             accept_s;
    logic             load_s;

    // Clamp length, left-align the payload and evaluate the handshake
    always_comb begin
        if (len > WIDTH_L) begin
            len_eff_s = WIDTH_L;
        end else begin
            len_eff_s = len;
        end
        aligned_s = data << (WIDTH_L - len_eff_s);
        if (reset) begin
            ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            ready_s = 1'b1;
        end else if ((state_r == SHIFT) && (cnt_r == LENW'(1)) && !HAS_GAP) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = valid & ready_s;
        load_s   = accept_s & (len_eff_s != {LENW{1'b0}});
    end

    // Next-state and next-output logic; outputs are registered below
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
        gap_s   = gap_r;
        dout_s  = 1'b0;
        vld_s   = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = SHIFT;
                    dout_s  = aligned_s[WIDTH-1];
                    vld_s   = 1'b1;
                    last_s  = (len_eff_s == LENW'(1));
                    shreg_s = aligned_s << 1;
                    cnt_s   = len_eff_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r > LENW'(1)) begin
                    dout_s  = shreg_r[WIDTH-1];
                    vld_s   = 1'b1;
                    last_s  = (cnt_r == LENW'(2));
                    shreg_s = shreg_r << 1;
                    cnt_s   = cnt_r - LENW'(1);
                end else if (HAS_GAP) begin
                    state_s = GAP;
                    gap_s   = GAP_L;
                    cnt_s   = {LENW{1'b0}};
                    shreg_s = {WIDTH{1'b0}};
                end else if (load_s) begin
                    // back-to-back word: first bit follows the last bit directly
                    dout_s  = aligned_s[WIDTH-1];
                    vld_s   = 1'b1;
                    last_s  = (len_eff_s == LENW'(1));
                    shreg_s = aligned_s << 1;
                    cnt_s   = len_eff_s;
                end else begin
                    state_s = IDLE;
                    cnt_s   = {LENW{1'b0}};
                    shreg_s = {WIDTH{1'b0}};
                end
            end
            GAP: begin
                if (gap_r <= 4'd1) begin
                    state_s = IDLE;
                    gap_s   = 4'd0;
                end else begin
                    gap_s   = gap_r - 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {LENW{1'b0}};
                gap_s   = 4'd0;
                shreg_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, datapath and output registers; reset abandons any word in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {LENW{1'b0}};
            gap_r   <= 4'd0;
            dout_r  <= 1'b0;
            vld_r   <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            cnt_r   <= cnt_s;
            gap_r   <= gap_s;
            dout_r  <= dout_s;
            vld_r   <= vld_s;
            last_r  <= last_s;
        end
    end

    assign ready    = ready_s;
    assign dout     = dout_r;
    assign dout_vld = vld_r;
    assign last     = last_r;
    assign busy     = (state_r != IDLE);

`ifdef IIITB_SEQ_TX_CNT_EN
    iiitb_seq_patcnt u_patcnt (
        .clk   (clk),
        .reset (reset),
        .din   (dout_r),
        .cnt   (exp_cnt)
    );
`endif

endmodule

// File: tb/tb_iiitb_seq_tx.sv
// Self-checking bench for iiitb_seq_tx: a table of words on a GAP_CYCLES=0
// instance checked through an expected-bit queue, plus hand sequences for
// reset, latency, back-to-back words, gap timing and mid-word reset.
module tb_iiitb_seq_tx;
    import iiitb_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] data0, data3;
    logic [3:0] len0, len3;
    logic       valid0, valid3;
    logic       ready0, dout0, dout_vld0, last0, busy0;
    logic       ready3, dout3, dout_vld3, last3, busy3;
`ifdef IIITB_SEQ_TX_CNT_EN
    logic [15:0] cnt0, cnt3;
`endif

    iiitb_seq_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .data(data0), .len(len0), .valid(valid0),
        .ready(ready0), .dout(dout0), .dout_vld(dout_vld0), .last(last0), .busy(busy0)
`ifdef IIITB_SEQ_TX_CNT_EN
        , .exp_cnt(cnt0)
`endif
    );

    iiitb_seq_tx #(.WIDTH(8), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .data(data3), .len(len3), .valid(valid3),
        .ready(ready3), .dout(dout3), .dout_vld(dout_vld3), .last(last3), .busy(busy3)
`ifdef IIITB_SEQ_TX_CNT_EN
        , .exp_cnt(cnt3)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         n;      // expected payload bit count
        logic [7:0] bits;   // expected payload, bit n-1 sent first
    } vec_t;

    vec_t       tbl [10];
    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         vld_seen = 0;
    bit         mon_en = 1'b0;
    logic [1:0] q0 [$];     // {dout, last} expected per payload bit
    logic [1:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            q0.push_back({bits[i], (i == 0)});
        end
    endtask

    task automatic wait_drain(input int max);
        int k;
        k = 0;
        while (q0.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("drain", q0.size(), 0);
    endtask

    task automatic send0(input logic [7:0] d, input logic [3:0] l, input logic [7:0] bits, input int n);
        chk("ready_pre", ready0, 1'b1);
        data0    = d;
        len0     = l;
        valid0   = 1'b1;
        vld_seen = 0;
        push_word(bits, n);
        tick();
        valid0 = 1'b0;
        @(negedge clk);
        chk("first_lat", dout_vld0, (n != 0));
        if (n == 0) begin
            chk("len0_ready", ready0, 1'b1);
            chk("len0_busy", busy0, 1'b0);
        end
        wait_drain(40);
        tick();
        tick();
        chk("vld_len", vld_seen, n);
    endtask

    // Scoreboard monitor for dut0: every payload bit pops one expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_vld0 === 1'b1) begin
                vld_seen++;
                chk("vld_expected", (q0.size() != 0), 1'b1);
                if (q0.size() != 0) begin
                    mon_e = q0.pop_front();
                    chk("dout_last", {dout0, last0}, mon_e);
                end
            end else begin
                chk("idle_dout", {dout0, last0}, 2'b00);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat_d;
        tbl[0] = '{8'h0A, 4'd4,  4, 8'h0A};
        tbl[1] = '{8'hFF, 4'd3,  3, 8'h07};
        tbl[2] = '{8'hA5, 4'd8,  8, 8'hA5};
        tbl[3] = '{8'h01, 4'd1,  1, 8'h01};
        tbl[4] = '{8'hF0, 4'd5,  5, 8'h10};
        tbl[5] = '{8'h3C, 4'd12, 8, 8'h3C};
        tbl[6] = '{8'h5A, 4'd0,  0, 8'h00};
        tbl[7] = '{8'hC3, 4'd15, 8, 8'hC3};
        tbl[8] = '{8'h00, 4'd2,  2, 8'h00};
        tbl[9] = '{8'h96, 4'd7,  7, 8'h16};

        reset  = 1'b1;
        valid0 = 1'b0; data0 = 8'h00; len0 = 4'd0;
        valid3 = 1'b0; data3 = 8'h00; len3 = 4'd0;

        // reset held two cycles, then released
        tick();
        tick();
        @(negedge clk);
        chk("ready_in_reset", ready0, 1'b0);
        chk("vld_in_reset", dout_vld0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dout", dout0, 1'b0);
        chk("rst_vld", dout_vld0, 1'b0);
        chk("rst_last", last0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ready", ready0, 1'b1);
        chk("rst_ready3", ready3, 1'b1);
`ifdef IIITB_SEQ_TX_CNT_EN
        chk("rst_cnt", cnt0, 16'd0);
`endif
        mon_en = 1'b1;

        // 0x0A, 4 bits: cycle-exact check of 1,0,1,0
        @(posedge clk); #1;
        data0 = 8'h0A; len0 = 4'd4; valid0 = 1'b1;
        push_word(8'h0A, 4);
        tick();
        valid0 = 1'b0;
        pat_d = 5'b10100;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("t2_dout", dout0, pat_d[5-k]);
            chk("t2_vld", dout_vld0, (k <= 4));
            chk("t2_last", last0, (k == 4));
`ifdef IIITB_SEQ_TX_CNT_EN
            if (k >= 4) chk("t2_cnt", cnt0, (k == 5) ? 16'd1 : 16'd0);
`endif
        end
        chk("t2_ready", ready0, 1'b1);
        tick();

        // table-driven words, including len=0 and clamped lengths
        for (int i = 0; i < 10; i++) begin
            send0(tbl[i].data, tbl[i].len, tbl[i].bits, tbl[i].n);
        end

        // back-to-back 0xAA words with valid held
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data0 = 8'hAA; len0 = 4'd8; valid0 = 1'b1;
        push_word(8'hAA, 8);
        push_word(8'hAA, 8);
        tick();
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            chk("t3_vld", dout_vld0, (k <= 16));
            chk("t3_last", last0, (k == 8 || k == 16));
            chk("t3_ready", ready0, (k == 8 || k >= 16));
`ifdef IIITB_SEQ_TX_CNT_EN
            if (k == 16) chk("t3_cnt16", cnt0, 16'd6);
            if (k == 17) chk("t3_cnt17", cnt0, 16'd7);
`endif
            if (k == 8) begin
                @(posedge clk); #1;
                valid0 = 1'b0;
            end
        end
        chk("t3_drain", q0.size(), 0);

        // gap instance: 0x05, 3 bits, then three idle cycles
        @(posedge clk); #1;
        data3 = 8'h05; len3 = 4'd3; valid3 = 1'b1;
        tick();
        valid3 = 1'b0;
        pat_d = 5'b10100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t4_dout", dout3, (k <= 3) ? pat_d[5-k] : 1'b0);
            chk("t4_vld", dout_vld3, (k <= 3));
            chk("t4_last", last3, (k == 3));
            chk("t4_ready", ready3, (k == 7));
            chk("t4_busy", busy3, (k <= 6));
        end

        // reset during bit 3 of 0xB7, then a new word right after release
        @(posedge clk); #1;
        data0 = 8'hB7; len0 = 4'd8; valid0 = 1'b1;
        q0.push_back(2'b10);
        q0.push_back(2'b00);
        q0.push_back(2'b10);
        tick();
        valid0 = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_bit3_vld", dout_vld0, 1'b1);
        chk("t6_ready_rst", ready0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        vld_seen = 0;
        data0 = 8'hC5; len0 = 4'd8; valid0 = 1'b1;
        push_word(8'hC5, 8);
        @(negedge clk);
        chk("t6_vld", dout_vld0, 1'b0);
        chk("t6_dout", dout0, 1'b0);
        chk("t6_busy", busy0, 1'b0);
        chk("t6_ready", ready0, 1'b1);
`ifdef IIITB_SEQ_TX_CNT_EN
        chk("t6_cnt", cnt0, 16'd0);
`endif
        @(posedge clk); #1;
        valid0 = 1'b0;
        @(negedge clk);
        chk("t6_first", dout_vld0, 1'b1);
        wait_drain(40);
        tick();
        tick();
        chk("t6_vld_len", vld_seen, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/iiitb_seq_tx.md
Name: iiitb_seq_tx

Overview:
- Serial pattern transmitter: the driving end of the serial `din` line consumed by the team's "1010" sequence detector.
- Accepts a parallel word plus a bit count over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Optionally inserts idle gap cycles between words.
- Used as on-chip stimulus source and as the TX side of detector loopback tests.

Parameters:
- WIDTH, 8, max bits per word (2..32).
- GAP_CYCLES, 0, idle cycles (dout=0) inserted after each word (0..15).
- LENW, $clog2(WIDTH+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data  input  WIDTH  word to send; bits [len-1:0] are transmitted, MSB first.
- len  input  LENW  number of bits to send; 0 = accept and drop; >WIDTH clamps to WIDTH.
- valid  input  1  word present.
- ready  output  1  block can accept a word.
- dout  output  1  serial bit, connects to detector din.
- dout_vld  output  1  dout carries a payload bit.
- last  output  1  high with the final payload bit of a word.
- busy  output  1  state != IDLE.

Behaviour:
- One clock domain. Reset is synchronous, active-high; it dominates all other inputs.
- Reset values: state=IDLE, dout=0, dout_vld=0, last=0, bit counter=0, gap counter=0, shift register=0.
- ready = (state==IDLE) & !reset. Also high in SHIFT on the last-bit cycle when GAP_CYCLES==0, which allows back-to-back words.
- Handshake:
  - Accept on a rising edge with valid & ready.
  - data and len must be held while valid & !ready; valid may drop without acceptance.
  - Inputs while ready=0 are ignored.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: on accept with len!=0 -> SHIFT; load shreg = data << (WIDTH-len), cnt = len.
  - IDLE: on accept with len==0 -> stay IDLE. Nothing is emitted and ready stays high.
  - SHIFT: each cycle dout=shreg[WIDTH-1], dout_vld=1, then shreg<<=1 and cnt--.
  - SHIFT: last=1 when cnt==1. Then -> GAP if GAP_CYCLES>0, else IDLE. With GAP_CYCLES==0 and a concurrent accept, stay in SHIFT and load the new word.
  - GAP: dout=0, dout_vld=0 for exactly GAP_CYCLES cycles, then -> IDLE.
- Latency:
  - The first bit appears on dout in the cycle after the accepting edge (registered outputs).
  - A word of len bits occupies dout_vld for exactly len consecutive cycles.
- Outside SHIFT, dout=0 and dout_vld=0.
- Reset mid-word: the word is abandoned and outputs go to reset values on the same edge. No partial resume.

Optional Feature:
- Macro: IIITB_SEQ_TX_CNT_EN.
- Defined: adds output `exp_cnt [15:0]`, a saturating count (stops at 16'hFFFF) of overlapping "1010" occurrences in the dout stream.
  - Sampled every clock, including idle and gap zeros, so it matches a detector that samples every cycle.
  - Pattern history persists across word boundaries.
  - Increments in the cycle after the completing 0 is on dout.
  - Reset clears the count and history.
- Not defined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package iiitb_seq_pkg: state enum (IDLE, SHIFT, GAP), the PATTERN constant 4'b1010, and CNT_W=16.
- Natural sub-module: iiitb_seq_patcnt. It is the optional 4-bit history/compare/saturating counter, instantiated only under IIITB_SEQ_TX_CNT_EN and reusable as a reference model for the detector.

Test Plan:
1. Reset held 2 cycles then released with valid=0 -> dout=0, dout_vld=0, last=0, busy=0, ready=1 (cnt build: exp_cnt=0).
2. data=8'h0A, len=4, accepted at edge k -> dout=1,0,1,0 at cycles k+1..k+4, dout_vld high 4 cycles, last only at k+4, ready=1 at k+5; exp_cnt=1 one cycle after the final 0.
3. data=8'hAA, len=8, GAP_CYCLES=0, then a second 8'hAA presented with valid held -> 16 contiguous dout_vld cycles, last at bits 8 and 16; exp_cnt=7 (overlapping across the boundary).
4. GAP_CYCLES=3, data=8'h05, len=3 -> dout 1,0,1; then 3 cycles of dout=0 with ready=0; ready=1 on the 4th cycle after last.
5. len=0 with valid -> no dout_vld, ready stays 1. len=12 with WIDTH=8 -> exactly 8 bits sent.
6. Reset asserted on bit 3 of an 8-bit word -> next cycle dout=0, dout_vld=0, state IDLE, exp_cnt=0. New word accepted immediately after release transmits fully.
